// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage (priority, no backpressure except wb_stall) and the long-latency load
//   unit, whose results are buffered in a small FIFO. Writeback writes that hit
//   a queued load's destination kill that entry (write-after-write ordering).
//   If the FIFO head goes un-popped for STARVE_MAX cycles, writeback is held
//   off for one cycle so the head can drain.
//
// Optional feature macro: RF_ARB_STATS_EN (adds stall_cnt / kill_cnt outputs).
//
// Ports:
//   clk              in   clock, rising edge
//   rstf             in   asynchronous active-low reset
//   wb_we/rd/data    in   writeback write request, destination, data
//   wb_stall         out  registered; writeback request not accepted this cycle
//   lu_valid/rd/data in   load result handshake, destination, data
//   lu_ready         out  FIFO can accept (not full, from registered count)
//   rf_we/rd/wdata   out  registered register-file write port
//   pending_rd_mask  out  one bit per register with a live (non-killed) entry
//   stall_cnt        out  (RF_ARB_STATS_EN) cycles with wb_stall=1
//   kill_cnt         out  (RF_ARB_STATS_EN) FIFO entries killed
module regfile_write_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstf,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        wb_stall,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wdata,
   output logic [31:0] pending_rd_mask
`ifdef RF_ARB_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] kill_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FORCE = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [4:0]       rd_mem   [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] killed_q, killed_d;
   logic [DEPTH-1:0] kill_hit;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Control state
   state_t           state_q;
   logic [SW-1:0]    starve_q;
   logic [SW-1:0]    starve_inc;
   logic             wb_stall_q;

   // Registered write port
   logic             rf_we_q;
   logic [4:0]       rf_rd_q;
   logic [31:0]      rf_wdata_q;

   logic             full, empty;
   logic             wb_grant, pop, push, head_live;
   logic [31:0]      entry_mask [DEPTH];
   logic [31:0]      mask_c;

   assign full       = (cnt_q == FULL_CNT);
   assign empty      = (cnt_q == '0);
   assign lu_ready   = !full;
   assign wb_stall   = wb_stall_q;
   assign rf_we      = rf_we_q;
   assign rf_rd      = rf_rd_q;
   assign rf_wdata   = rf_wdata_q;
   assign starve_inc = starve_q + SW'(1);

   // x0 writes are dropped here so they never reach rf_we.
   assign wb_grant  = wb_we && (wb_rd != 5'd0) && !wb_stall_q;
   assign pop       = !wb_grant && !empty;
   assign head_live = !killed_q[rd_ptr_q];

   // Accepted loads to x0, or to the register writeback is writing this very
   // cycle, are dropped: the load is older, so its value is already dead.
   assign push = lu_valid && !full && (lu_rd != 5'd0) &&
                 !(wb_grant && (lu_rd == wb_rd));

   assign cnt_d = cnt_q + CW'(push) - CW'(pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign kill_hit[gi] = wb_grant && valid_q[gi] && !killed_q[gi] &&
                               (rd_mem[gi] == wb_rd);
         assign entry_mask[gi] = (valid_q[gi] && !killed_q[gi]) ?
                                 (32'd1 << rd_mem[gi]) : 32'd0;
      end
   endgenerate

   always_comb begin
      mask_c = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         mask_c = mask_c | entry_mask[i];
      end
   end
   assign pending_rd_mask = mask_c & ~32'd1;

   // Push and pop never target the same slot: a pop needs a non-empty FIFO
   // and a push needs a non-full one, so the pointers differ whenever both fire.
   always_comb begin
      valid_d  = valid_q;
      killed_d = killed_q | kill_hit;
      if (pop) begin
         valid_d[rd_ptr_q]  = 1'b0;
         killed_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
         valid_d[wr_ptr_q]  = 1'b1;
         killed_d[wr_ptr_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr_q]   <= lu_rd;
         data_mem[wr_ptr_q] <= lu_data;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         valid_q  <= '0;
         killed_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         killed_q <= killed_d;
         cnt_q    <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Write port: writeback wins; a killed head is consumed silently.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else if (wb_grant) begin
         rf_we_q    <= 1'b1;
         rf_rd_q    <= wb_rd;
         rf_wdata_q <= wb_data;
      end else if (pop && head_live) begin
         rf_we_q    <= 1'b1;
         rf_rd_q    <= rd_mem[rd_ptr_q];
         rf_wdata_q <= data_mem[rd_ptr_q];
      end else begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end
   end

   // Starvation FSM. The counter only advances while a head sits in the FIFO
   // un-popped; FORCE stalls writeback for one cycle so the head wins.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         wb_stall_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               starve_q   <= '0;
               wb_stall_q <= 1'b0;
               if (cnt_d != '0) state_q <= DRAIN;
            end
            DRAIN: begin
               if (cnt_d == '0) begin
                  state_q    <= IDLE;
                  starve_q   <= '0;
                  wb_stall_q <= 1'b0;
               end else if (pop) begin
                  starve_q <= '0;
               end else begin
                  starve_q <= starve_inc;
                  if (starve_inc == STARVE_LIM) begin
                     state_q    <= FORCE;
                     wb_stall_q <= 1'b1;
                  end
               end
            end
            FORCE: begin
               starve_q   <= '0;
               wb_stall_q <= 1'b0;
               state_q    <= (cnt_d != '0) ? DRAIN : IDLE;
            end
            default: begin
               state_q    <= IDLE;
               starve_q   <= '0;
               wb_stall_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef RF_ARB_STATS_EN
   logic [31:0] stall_cnt_q, kill_cnt_q;
   logic [31:0] kill_num;

   always_comb begin
      kill_num = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_num = kill_num + 32'(kill_hit[i]);
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         stall_cnt_q <= 32'd0;
         kill_cnt_q  <= 32'd0;
      end else begin
         if (wb_stall_q) stall_cnt_q <= stall_cnt_q + 32'd1;
         kill_cnt_q <= kill_cnt_q + kill_num;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rstf;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [31:0] pending_rd_mask;
`ifdef RF_ARB_STATS_EN
   logic [31:0] stall_cnt, kill_cnt;
`endif

   regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rstf(rstf),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .pending_rd_mask(pending_rd_mask)
`ifdef RF_ARB_STATS_EN
      , .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of outstanding loads plus starvation bookkeeping.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          killed;
   } ent_t;
   ent_t m_q[$];
   int   m_starve;
   bit   m_stall;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic [31:0] e_mask;
      logic        e_stall;
      logic        e_ready;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m = 32'd0;
      foreach (m_q[i]) if (!m_q[i].killed) m[m_q[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
   endtask

   task automatic drive_idle();
      wb_we = 0; wb_rd = 0; wb_data = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
   endtask

   task automatic do_reset();
      drive_idle();
      rstf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstf = 1'b1;
      model_clear();
   endtask

   // One clock of stimulus, checked against the reference model.
   task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      bit gw, acc, popped, was_nonempty;
      ent_t h;
      logic ewe;
      logic [4:0] erd;
      logic [31:0] edat;
      @(negedge clk);
      wb_we = we; wb_rd = rd; wb_data = d;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      #1;
      chk("lu_ready", {31'd0, lu_ready}, {31'd0, m_q.size() < DEPTH});
      chk("mask", pending_rd_mask, model_mask());
      chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
      gw  = we && rd != 0 && !m_stall;
      acc = lv && m_q.size() < DEPTH;
      was_nonempty = m_q.size() != 0;
      popped = 0; ewe = 0; erd = 0; edat = 0;
      if (gw) begin
         foreach (m_q[i]) if (m_q[i].rd == rd) m_q[i].killed = 1'b1;
         ewe = 1; erd = rd; edat = d;
      end else if (was_nonempty) begin
         h = m_q.pop_front();
         popped = 1;
         ewe = !h.killed; erd = h.rd; edat = h.data;
      end
      if (acc && lrd != 0 && !(gw && lrd == rd)) m_q.push_back('{lrd, ld, 1'b0});
      if (m_stall) begin
         m_stall = 0; m_starve = 0;
      end else if (popped || m_q.size() == 0) begin
         m_starve = 0;
      end else if (was_nonempty) begin
         m_starve++;
         if (m_starve == STARVE_MAX) begin m_stall = 1; m_starve = 0; end
      end
      @(posedge clk);
      #1;
      chk("rf_we", {31'd0, rf_we}, {31'd0, ewe});
      if (ewe) begin
         chk("rf_rd", {27'd0, rf_rd}, {27'd0, erd});
         chk("rf_wdata", rf_wdata, edat);
      end
      $display("step wb=%0d/%0d lu=%0d/%0d -> rf_we=%0d rd=%0d data=%0h stall=%0d q=%0d",
               we, rd, lv, lrd, rf_we, rf_rd, rf_wdata, wb_stall, m_q.size());
   endtask

   initial begin
      int stall_cycles, first_stall;
      bit found;

      // we rd data lv lrd ldata | e_we e_rd e_data e_mask e_stall e_ready
      vecs[0] = '{0, 0, 0,        1, 5, 32'hDEAD, 0, 0, 0,        32'h20,  0, 1};
      vecs[1] = '{0, 0, 0,        0, 0, 0,        1, 5, 32'hDEAD, 32'h0,   0, 1};
      vecs[2] = '{1, 3, 32'h11,   1, 7, 32'hAAAA, 1, 3, 32'h11,   32'h80,  0, 1};
      vecs[3] = '{0, 0, 0,        0, 0, 0,        1, 7, 32'hAAAA, 32'h0,   0, 1};
      vecs[4] = '{0, 0, 0,        1, 9, 32'h99,   0, 0, 0,        32'h200, 0, 1};
      vecs[5] = '{1, 9, 32'h22,   0, 0, 0,        1, 9, 32'h22,   32'h0,   0, 1};
      vecs[6] = '{0, 0, 0,        0, 0, 0,        0, 0, 0,        32'h0,   0, 1};
      vecs[7] = '{0, 0, 0,        0, 0, 0,        0, 0, 0,        32'h0,   0, 1};
      vecs[8] = '{1, 0, 32'h55,   1, 0, 32'h66,   0, 0, 0,        32'h0,   0, 1};
      vecs[9] = '{0, 0, 0,        0, 0, 0,        0, 0, 0,        32'h0,   0, 1};

      drive_idle();
      rstf = 1'b0;
      #12;
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_mask", pending_rd_mask, 32'd0);
      chk("rst_ready", {31'd0, lu_ready}, 32'd1);
      $display("reset state checked");
      do_reset();

      // Table-driven directed vectors; expectations sampled after the edge.
      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         wb_we = vecs[v].we; wb_rd = vecs[v].rd; wb_data = vecs[v].data;
         lu_valid = vecs[v].lv; lu_rd = vecs[v].lrd; lu_data = vecs[v].ldata;
         @(posedge clk);
         #1;
         chk("vec_rf_we", {31'd0, rf_we}, {31'd0, vecs[v].e_we});
         if (vecs[v].e_we) begin
            chk("vec_rf_rd", {27'd0, rf_rd}, {27'd0, vecs[v].e_rd});
            chk("vec_rf_wdata", rf_wdata, vecs[v].e_data);
         end
         chk("vec_mask", pending_rd_mask, vecs[v].e_mask);
         chk("vec_stall", {31'd0, wb_stall}, {31'd0, vecs[v].e_stall});
         chk("vec_ready", {31'd0, lu_ready}, {31'd0, vecs[v].e_ready});
         $display("vec %0d rf_we=%0d rd=%0d data=%0h mask=%0h", v, rf_we, rf_rd, rf_wdata, pending_rd_mask);
      end

      // Starvation: one queued load, writeback to x1 every cycle.
      do_reset();
      stall_cycles = 0; first_stall = -1;
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 5'd1, 32'h100 + k, k == 0, 5'd12, 32'hC0);
         if (wb_stall) begin
            stall_cycles++;
            if (first_stall < 0) first_stall = k + 1;
         end
      end
      chk("starve_stall_cycles", stall_cycles, 1);
      chk("starve_first_stall", first_stall, STARVE_MAX + 1);

      // Full FIFO under continuous writeback, then async reset during FORCE.
      do_reset();
      step(1'b1, 5'd2, 32'h200, 1'b1, 5'd4, 32'h400);
      step(1'b1, 5'd2, 32'h201, 1'b1, 5'd6, 32'h600);
      chk("full_not_ready", {31'd0, lu_ready}, 32'd0);
      found = (m_stall && m_q.size() == 2);
      for (int k = 0; k < 20 && !found; k++) begin
         step(1'b1, 5'd2, 32'h210 + k, 1'b1, 5'd8 + 5'(k % 4), 32'h800 + k);
         found = (m_stall && m_q.size() == 2);
      end
      chk("force_with_two_reached", {31'd0, found}, 32'd1);
      chk("pre_reset_stall", {31'd0, wb_stall}, 32'd1);
      #2;
      rstf = 1'b0;
      #1;
      chk("async_rf_we", {31'd0, rf_we}, 32'd0);
      chk("async_rf_rd", {27'd0, rf_rd}, 32'd0);
      chk("async_rf_wdata", rf_wdata, 32'd0);
      chk("async_stall", {31'd0, wb_stall}, 32'd0);
      chk("async_mask", pending_rd_mask, 32'd0);
      @(negedge clk);
      drive_idle();
      rstf = 1'b1;
      model_clear();
      #1;
      chk("post_rst_ready", {31'd0, lu_ready}, 32'd1);
      chk("post_rst_mask", pending_rd_mask, 32'd0);
      $display("async reset during FORCE checked");

      // Randomized traffic with small register range to provoke collisions.
      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
